// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: one full-subtractor cell processes a and b
//   LSB-first, one bit per clock. An operation takes WIDTH SHIFT cycles
//   followed by a single DONE cycle.
//
//   Optional feature: define SERIAL_SUBTRACTOR_SAT_EN to clamp diff to zero
//   whenever the final borrow is set (saturating subtraction). borrow still
//   reports 1 in that case.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, only honoured in IDLE
//   a       in   WIDTH  minuend (unsigned)
//   b       in   WIDTH  subtrahend (unsigned)
//   busy    out  high during SHIFT
//   done    out  one-cycle pulse, diff/borrow valid from this cycle
//   diff    out  WIDTH  registered a-b
//   borrow  out  registered final borrow (1 = a<b)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             bint;
    logic [CW-1:0]    cnt;

    logic             x, y, d, bo, last;
    logic [WIDTH-1:0] res_nx;

    // full-subtractor cell on the current LSBs
    assign x      = a_sh[0];
    assign y      = b_sh[0];
    assign d      = x ^ y ^ bint;
    assign bo     = (~x & y) | (~(x ^ y) & bint);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign res_nx = {d, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE:  if (start) nstate = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) nstate = DONE;
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // The result is committed on the edge that enters DONE, so diff/borrow
    // already show the new value during the done pulse and stay put until
    // the next operation commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            bint   <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        res  <= '0;
                        bint <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    res  <= res_nx;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bint <= bo;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                        diff <= bo ? '0 : res_nx;
`else
                        diff <= res_nx;
`endif
                        borrow <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). A phase-counting
//   behavioural model predicts busy/done/diff/borrow from plain arithmetic;
//   a compare process checks every falling edge. Directed cases pin literal
//   values, then randomized traffic runs against the model.
module tb_serial_subtractor;
    localparam int W = 8;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;

    int checks = 0;
    int fails  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0: idle, 1..W: computing, W+1: result cycle
    int           phase;
    int           ca, cb;
    logic [W-1:0] m_diff;
    logic         m_borrow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 0;
            ca       <= 0;
            cb       <= 0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                phase <= 1;
                ca    <= int'(a);
                cb    <= int'(b);
            end
        end else if (phase <= W) begin
            phase <= phase + 1;
            if (phase == W) begin
                m_borrow <= (ca < cb);
                m_diff   <= (SAT && ca < cb) ? '0 : W'((ca + (1 << W) - cb) % (1 << W));
            end
        end else begin
            phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("busy",   {31'b0, busy},   {31'b0, (phase >= 1 && phase <= W)});
        check("done",   {31'b0, done},   {31'b0, (phase == W + 1)});
        check("diff",   {24'b0, diff},   {24'b0, m_diff});
        check("borrow", {31'b0, borrow}, {31'b0, m_borrow});
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] ed, input logic eb);
        int  nb;
        bit  seen;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        nb = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (busy) nb++;
            if (done) begin
                seen = 1;
                check("done_cycle", i, W + 1);
                check("lit_diff", {24'b0, diff}, {24'b0, ed});
                check("lit_borrow", {31'b0, borrow}, {31'b0, eb});
            end
            if (!seen) @(negedge clk);
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        check("busy_cycles", nb, W);
    endtask

    initial begin
        int ndone;
        int dt[3];
        logic [W-1:0] sd;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_diff", {24'b0, diff}, 0);
        check("rst_borrow", {31'b0, borrow}, 0);
        rst_n = 1'b1;

        // basic and boundary values
        run_op(8'h05, 8'h03, 8'h02, 1'b0);
        run_op(8'h03, 8'h05, SAT ? 8'h00 : 8'hFE, 1'b1);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op(8'h00, 8'h01, SAT ? 8'h00 : 8'hFF, 1'b1);
        run_op(8'h80, 8'h00, 8'h80, 1'b0);

        // second start during SHIFT is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 4) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
            else start = 1'b0;
            if (done) begin
                ndone++;
                check("ign_diff", {24'b0, diff}, 32'h0F);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_ndone", ndone, 1);

        // reset in the middle of SHIFT
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);   // now in 5th SHIFT cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_diff", {24'b0, diff}, 0);
        check("arst_borrow", {31'b0, borrow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("arst_nodone", {31'b0, done}, 0);
        end
        run_op(8'h09, 8'h04, 8'h05, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; a = W'($urandom); b = W'($urandom);
        ndone = 0; sd = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) dt[ndone] = i;
                ndone++;
                sd = diff;
            end else if (ndone > 0) begin
                check("b2b_hold", {24'b0, diff}, {24'b0, sd});
            end
            a = W'($urandom); b = W'($urandom);
        end
        start = 1'b0;
        check("b2b_ndone", ndone, 3);
        check("b2b_gap1", dt[1] - dt[0], W + 2);
        check("b2b_gap2", dt[2] - dt[1], W + 2);

        // randomized traffic
        repeat (12) @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       begin a = '0;   b = W'($urandom); end
                1:       begin a = '1;   b = W'($urandom); end
                2:       begin a = W'($urandom); b = a;    end
                default: begin a = W'($urandom); b = W'($urandom); end
            endcase
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit 2000000 reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
